// File: rtl/toy_imem_responder_pkg.sv
// Shared constants for the instruction-memory responder slice.
// Holds the default address/data widths, the byte address of word 0, the
// array depth and the response FIFO depth used as parameter defaults by
// toy_imem_responder_if and toy_imem_responder.
// Optional build feature: TOY_IMEM_LOAD_EN (see toy_imem_responder.sv).
package toy_imem_responder_pkg;
  localparam int                 IMEM_ADDR_WIDTH  = 32;
  localparam int                 IMEM_INST_WIDTH  = 32;
  localparam logic [31:0]        IMEM_BASE_ADDR   = 32'h8000_0000;
  localparam int                 IMEM_DEPTH_WORDS = 4096;
  localparam int                 IMEM_RSP_DEPTH   = 4;
endpackage

// File: rtl/toy_imem_responder_if.sv
// Fetch <-> instruction memory port pair.
//   mem_req_vld/rdy/addr : fetch request (byte address, [1:0] ignored)
//   mem_ack_vld/rdy/data : instruction word response, in request order
//   flush                : drop every outstanding response (fetch redirect)
// master = fetch unit, slave = memory responder.
interface toy_imem_responder_if
  import toy_imem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int INST_WIDTH = IMEM_INST_WIDTH
);
  logic                  mem_req_vld;
  logic                  mem_req_rdy;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_ack_vld;
  logic                  mem_ack_rdy;
  logic [INST_WIDTH-1:0] mem_ack_data;
  logic                  flush;

  modport master (
    output mem_req_vld, mem_req_addr, mem_ack_rdy, flush,
    input  mem_req_rdy, mem_ack_vld, mem_ack_data
  );

  modport slave (
    input  mem_req_vld, mem_req_addr, mem_ack_rdy, flush,
    output mem_req_rdy, mem_ack_vld, mem_ack_data
  );
endinterface

// File: rtl/toy_imem_rsp_fifo.sv
// Response FIFO for the instruction-memory responder.
//   clk, rst_n     : clock, synchronous active-low reset (also zeroes storage
//                    so the head reads 0 after reset)
//   push/push_data : enqueue one word
//   pop            : dequeue the head (ignored when empty)
//   clear          : drop all entries (has priority over push/pop)
//   head           : current head word
//   cnt            : number of valid entries, 0..DEPTH
// A push on a full FIFO is taken only when a pop happens in the same cycle.
module toy_imem_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_pop  = pop & (cnt != '0);
  assign do_push = push & ((cnt != FULL) | do_pop);

  // Pointers are PW bits wide, so +1 wraps modulo DEPTH on its own.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head = store[rd_ptr];
endmodule

// File: rtl/toy_imem_responder.sv
// Instruction-memory slave for the fetch unit.
//   clk, rst_n : clock, synchronous active-low reset (array contents kept)
//   mem        : toy_imem_responder_if.slave (request, response, flush)
//   load_vld/load_addr/load_data : present only with TOY_IMEM_LOAD_EN;
//                write one array word and block request acceptance that cycle.
// Word-addressed array with 1-cycle read (s1 stage), then a response FIFO.
// mem_req_rdy is issued on credit: a request is accepted only when the FIFO
// plus the s1 stage have a free slot, so mem_ack_rdy never reaches mem_req_rdy
// combinationally. flush empties the FIFO and discards the word in s1; a
// request accepted in the flush cycle itself is the redirect target and kept.
// Optional build feature: TOY_IMEM_LOAD_EN.
module toy_imem_responder
  import toy_imem_responder_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = IMEM_ADDR_WIDTH,
  parameter int                    INST_WIDTH  = IMEM_INST_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = IMEM_BASE_ADDR,
  parameter int                    DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter int                    RSP_DEPTH   = IMEM_RSP_DEPTH,
  parameter string                 INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef TOY_IMEM_LOAD_EN
  input  logic                  load_vld,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [INST_WIDTH-1:0] load_data,
`endif
  toy_imem_responder_if.slave   mem
);
  localparam int          IW  = $clog2(DEPTH_WORDS);
  localparam int          CW  = $clog2(RSP_DEPTH) + 1;
  localparam logic [CW:0] LIM = (CW+1)'(RSP_DEPTH);

  logic [INST_WIDTH-1:0] mem_array [DEPTH_WORDS];

  // Offset from word 0; upper bits drop out, so the index wraps mod depth.
  logic [ADDR_WIDTH-1:0] rd_off;
  logic [IW-1:0]         rd_idx;
  assign rd_off = mem.mem_req_addr - BASE_ADDR;
  assign rd_idx = rd_off[IW+1:2];

  logic load_busy;
`ifdef TOY_IMEM_LOAD_EN
  logic [ADDR_WIDTH-1:0] ld_off;
  logic [IW-1:0]         ld_idx;
  logic                  unused_ld;
  assign ld_off    = load_addr - BASE_ADDR;
  assign ld_idx    = ld_off[IW+1:2];
  assign unused_ld = ^{ld_off[ADDR_WIDTH-1:IW+2], ld_off[1:0]};
  assign load_busy = load_vld;
`else
  assign load_busy = 1'b0;
`endif

  logic unused_rd;
  assign unused_rd = ^{rd_off[ADDR_WIDTH-1:IW+2], rd_off[1:0]};

  logic                  s1_vld;
  logic [INST_WIDTH-1:0] s1_data;
  logic [CW-1:0]         fifo_cnt;
  logic [CW:0]           outstanding;
  logic                  accept;

  // Both terms registered: credit depends only on state, flush and load.
  assign outstanding     = {1'b0, fifo_cnt} + {{CW{1'b0}}, s1_vld};
  assign mem.mem_req_rdy = rst_n & ~load_busy & (mem.flush | (outstanding < LIM));
  assign accept          = mem.mem_req_vld & mem.mem_req_rdy;

  // Single-port array: a load and a read never share a cycle (rdy is low).
  always_ff @(posedge clk) begin
`ifdef TOY_IMEM_LOAD_EN
    if (load_vld) mem_array[ld_idx] <= load_data;
`endif
    if (accept) s1_data <= mem_array[rd_idx];
  end

  // s1 simply tracks this cycle's accept; a flush drops the old s1 word by
  // suppressing its push below.
  always_ff @(posedge clk) begin
    if (!rst_n) s1_vld <= 1'b0;
    else        s1_vld <= accept;
  end

  toy_imem_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (INST_WIDTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s1_vld & ~mem.flush),
    .push_data (s1_data),
    .pop       (mem.mem_ack_vld & mem.mem_ack_rdy),
    .clear     (mem.flush),
    .head      (mem.mem_ack_data),
    .cnt       (fifo_cnt)
  );

  assign mem.mem_ack_vld = ~mem.flush & (fifo_cnt != '0);
endmodule

// File: tb/tb_toy_imem_responder.sv
// Directed bench for toy_imem_responder with a queue-based reference model.
// The model keeps one entry per accepted request (cycle stamp + word) and
// derives rdy/vld/data from occupancy and the two-cycle read latency.
module tb_toy_imem_responder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  toy_imem_responder_if bus ();

`ifdef TOY_IMEM_LOAD_EN
  logic        load_vld;
  logic [31:0] load_addr;
  logic [31:0] load_data;
`endif

  toy_imem_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef TOY_IMEM_LOAD_EN
    .load_vld  (load_vld),
    .load_addr (load_addr),
    .load_data (load_data),
`endif
    .mem       (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return (i == 0) ? 32'h0000_0013 : (32'hA500_0000 | 32'(i));
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] w;
    w = (a - 32'h8000_0000) >> 2;
    return int'(w % 32'd4096);
  endfunction

  logic [31:0] model_mem [4096];

  // ---------------- reference model + per-cycle compare ----------------
  typedef struct {
    int          acc;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   cyc    = 0;
  bit   mon_en = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_rdy, exp_vld, ld;
      ld = 1'b0;
`ifdef TOY_IMEM_LOAD_EN
      ld = load_vld;
`endif
      exp_rdy = rst_n && !ld && (bus.flush || q.size() < 4);
      exp_vld = !bus.flush && q.size() > 0 && q[0].acc <= cyc - 2;
      chk("mon_req_rdy", 32'(bus.mem_req_rdy), 32'(exp_rdy));
      chk("mon_ack_vld", 32'(bus.mem_ack_vld), 32'(exp_vld));
      if (exp_vld) chk("mon_ack_data", bus.mem_ack_data, q[0].data);
      if (!rst_n) begin
        q.delete();
      end else begin
        if (bus.mem_ack_vld && bus.mem_ack_rdy && q.size() > 0) void'(q.pop_front());
        if (bus.flush) q.delete();
        if (bus.mem_req_vld && bus.mem_req_rdy)
          q.push_back('{acc: cyc, data: model_mem[widx(bus.mem_req_addr)]});
`ifdef TOY_IMEM_LOAD_EN
        if (load_vld) model_mem[widx(load_addr)] = load_data;
`endif
      end
      cyc++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  int n_acc;

  initial begin
    rst_n            = 1'b0;
    bus.mem_req_vld  = 1'b0;
    bus.mem_req_addr = '0;
    bus.mem_ack_rdy  = 1'b0;
    bus.flush        = 1'b0;
    for (int i = 0; i < 4096; i++) model_mem[i] = pat(i);
`ifdef TOY_IMEM_LOAD_EN
    load_vld  = 1'b0;
    load_addr = '0;
    load_data = '0;
    for (int i = 0; i < 72; i++) begin
      tick();
      load_vld  = 1'b1;
      load_addr = 32'h8000_0000 + 32'(4 * i);
      load_data = pat(i);
    end
    tick();
    load_vld = 1'b0;
`else
    for (int i = 0; i < 4096; i++) dut.mem_array[i] = pat(i);
`endif
    repeat (2) @(posedge clk);
    smp();
    chk("rst_req_rdy", 32'(bus.mem_req_rdy), 32'd0);
    chk("rst_ack_vld", 32'(bus.mem_ack_vld), 32'd0);
    chk("rst_ack_data", bus.mem_ack_data, 32'd0);
    mon_en = 1;

    // 1: release reset with a request to word 0 in the same cycle
    tick(); rst_n = 1'b1; bus.mem_ack_rdy = 1'b1;
    bus.mem_req_vld = 1'b1; bus.mem_req_addr = 32'h8000_0000;
    smp(); chk("t1_rdy", 32'(bus.mem_req_rdy), 32'd1);
    tick(); bus.mem_req_vld = 1'b0;
    smp(); chk("t1_vld_c1", 32'(bus.mem_ack_vld), 32'd0);
    tick();
    smp(); chk("t1_vld_c2", 32'(bus.mem_ack_vld), 32'd1);
    chk("t1_data", bus.mem_ack_data, 32'h0000_0013);
    tick();
    smp(); chk("t1_vld_c3", 32'(bus.mem_ack_vld), 32'd0);

    // 2: ten back-to-back requests, one ack per cycle
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c < 10) begin
        bus.mem_req_vld  = 1'b1;
        bus.mem_req_addr = 32'h8000_0000 + 32'(4 * c);
      end else bus.mem_req_vld = 1'b0;
      smp();
      if (c < 10) chk("t2_rdy", 32'(bus.mem_req_rdy), 32'd1);
      if (c >= 2) begin
        chk("t2_vld", 32'(bus.mem_ack_vld), 32'd1);
        chk("t2_data", bus.mem_ack_data, pat(c - 2));
      end
    end
    tick();
    smp(); chk("t2_drain", 32'(bus.mem_ack_vld), 32'd0);

    // 3: back-pressure, credit limit of four
    n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      bus.mem_ack_rdy  = 1'b0;
      bus.mem_req_vld  = 1'b1;
      bus.mem_req_addr = 32'h8000_0050 + 32'(4 * n_acc);
      smp();
      if (bus.mem_req_rdy) n_acc++;
    end
    chk("t3_accepts", 32'(n_acc), 32'd4);
    chk("t3_rdy_held", 32'(bus.mem_req_rdy), 32'd0);
    tick(); bus.mem_req_vld = 1'b0; bus.mem_ack_rdy = 1'b1;
    smp();
    chk("t3_vld0", 32'(bus.mem_ack_vld), 32'd1);
    chk("t3_data0", bus.mem_ack_data, 32'hA500_0014);
    chk("t3_rdy_no_comb", 32'(bus.mem_req_rdy), 32'd0);
    for (int k = 1; k < 4; k++) begin
      tick();
      smp();
      chk("t3_vld", 32'(bus.mem_ack_vld), 32'd1);
      chk("t3_data", bus.mem_ack_data, pat(20 + k));
      chk("t3_rdy_back", 32'(bus.mem_req_rdy), 32'd1);
    end
    tick();
    smp(); chk("t3_drain", 32'(bus.mem_ack_vld), 32'd0);

    // 4: flush with three outstanding, redirect request in the flush cycle
    bus.mem_ack_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.mem_req_vld  = 1'b1;
      bus.mem_req_addr = 32'h8000_0078 + 32'(4 * k);
      smp();
    end
    tick();
    bus.mem_req_addr = 32'h8000_0100; bus.flush = 1'b1; bus.mem_ack_rdy = 1'b1;
    smp();
    chk("t4_vld_f", 32'(bus.mem_ack_vld), 32'd0);
    chk("t4_rdy_f", 32'(bus.mem_req_rdy), 32'd1);
    tick(); bus.mem_req_vld = 1'b0; bus.flush = 1'b0;
    smp(); chk("t4_vld_f1", 32'(bus.mem_ack_vld), 32'd0);
    tick();
    smp();
    chk("t4_vld_f2", 32'(bus.mem_ack_vld), 32'd1);
    chk("t4_data_f2", bus.mem_ack_data, 32'hA500_0040);
    tick();
    smp(); chk("t4_vld_f3", 32'(bus.mem_ack_vld), 32'd0);

    // 5: low address bits ignored, wrap past the array end
    tick(); bus.mem_req_vld = 1'b1; bus.mem_req_addr = 32'h8000_0002;
    smp();
    tick(); bus.mem_req_addr = 32'h8000_4000;
    smp();
    tick(); bus.mem_req_vld = 1'b0;
    smp();
    chk("t5_vld_a", 32'(bus.mem_ack_vld), 32'd1);
    chk("t5_data_a", bus.mem_ack_data, 32'h0000_0013);
    tick();
    smp();
    chk("t5_vld_b", 32'(bus.mem_ack_vld), 32'd1);
    chk("t5_data_b", bus.mem_ack_data, 32'h0000_0013);
    tick();
    smp(); chk("t5_drain", 32'(bus.mem_ack_vld), 32'd0);

`ifdef TOY_IMEM_LOAD_EN
    // 6: load blocks acceptance, later read sees the new word
    tick();
    bus.mem_req_vld = 1'b1; bus.mem_req_addr = 32'h8000_0008;
    load_vld = 1'b1; load_addr = 32'h8000_0008; load_data = 32'hDEAD_BEEF;
    smp(); chk("t6_rdy_load", 32'(bus.mem_req_rdy), 32'd0);
    tick(); load_vld = 1'b0;
    smp(); chk("t6_rdy_after", 32'(bus.mem_req_rdy), 32'd1);
    tick(); bus.mem_req_vld = 1'b0;
    smp();
    tick();
    smp();
    chk("t6_vld", 32'(bus.mem_ack_vld), 32'd1);
    chk("t6_data", bus.mem_ack_data, 32'hDEAD_BEEF);
    tick();
    smp();
`endif

    // 7: reset mid-operation discards in-flight requests
    bus.mem_ack_rdy = 1'b0;
    tick(); bus.mem_req_vld = 1'b1; bus.mem_req_addr = 32'h8000_0004;
    smp();
    tick(); bus.mem_req_addr = 32'h8000_0008;
    smp();
    tick(); rst_n = 1'b0; bus.mem_req_vld = 1'b0;
    smp(); chk("t7_rdy_rst", 32'(bus.mem_req_rdy), 32'd0);
    tick(); rst_n = 1'b1;
    smp();
    chk("t7_vld_after", 32'(bus.mem_ack_vld), 32'd0);
    chk("t7_data_after", bus.mem_ack_data, 32'd0);
    chk("t7_rdy_after", 32'(bus.mem_req_rdy), 32'd1);
    tick(); bus.mem_ack_rdy = 1'b1;
    smp(); chk("t7_no_stale", 32'(bus.mem_ack_vld), 32'd0);
    tick();
    smp();

    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
